fx_kport_ctl: RTL and testbench



---
 rtl/fx_kport_pkg.sv | 17 +
 rtl/fx_kport_clkdiv.sv | 29 ++
 rtl/fx_kport_ctl.sv | 150 +++++++++++++++
 tb/tb_fx_kport_ctl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fx_kport_pkg.sv
// Shared types and widths for the PC-FX K-port serial controller.
package fx_kport_pkg;

   localparam int unsigned KP_WORD_W = 32;
   localparam int unsigned KP_DIV_W  = 9;
   localparam int unsigned KP_CNT_W  = 5;
   localparam logic [3:0]  PAD_ID    = 4'hF;

   typedef enum logic [2:0] {
      IDLE,
      LATCH,
      LOW,
      HIGH,
      DONE
   } kp_state_e;

endpackage

// File: rtl/fx_kport_clkdiv.sv
// CE-gated phase down-counter; tick_c marks the CE cycle on which the count sits at zero.
module fx_kport_clkdiv
   import fx_kport_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                ce,
   input  logic                load,
   input  logic [KP_DIV_W-1:0] load_val,
   output logic                tick_c
);

   logic [KP_DIV_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (ce) begin
         if (load) begin
            cnt <= load_val;
         end else if (cnt != '0) begin
            cnt <= cnt - KP_DIV_W'(1);
         end
      end
   end

   assign tick_c = ce & (cnt == '0);

endmodule

// File: rtl/fx_kport_ctl.sv
// PC-FX K-port transfer sequencer: latch pulse, NBITS full-duplex bit periods, END/INT.
// Optional pad-ID presence check enabled by defining FX_KPORT_PRESENCE_EN.
module fx_kport_ctl
   import fx_kport_pkg::*;
#(
   parameter int unsigned CLK_DIV = 16,
   parameter int unsigned NBITS   = 32
) (
   input  logic                 CLK,
   input  logic                 RES,
   input  logic                 CE,
   input  logic                 TRG,
   input  logic                 MOD,
   input  logic                 IOS,
   input  logic [KP_WORD_W-1:0] WDATA,
   input  logic                 RD_ACK,
   output logic [KP_WORD_W-1:0] RDATA,
   output logic                 BUSY,
   output logic                 END,
   output logic                 INT,
   output logic                 PRESENT,
   output logic                 KP_LATCH,
   output logic                 KP_CLK,
   output logic                 KP_DOUT,
   input  logic                 KP_DIN
);

   localparam logic [KP_DIV_W-1:0] HALF_LOAD  = KP_DIV_W'(CLK_DIV - 1);
   localparam logic [KP_DIV_W-1:0] LATCH_LOAD = KP_DIV_W'(2 * CLK_DIV - 1);
   localparam logic [KP_CNT_W-1:0] LAST_BIT   = KP_CNT_W'(NBITS - 1);
   localparam int unsigned         RSHIFT     = KP_WORD_W - NBITS;

   kp_state_e             state;
   logic [KP_WORD_W-1:0]  shift;
   logic [KP_CNT_W-1:0]   bit_cnt;
   logic                  tick_c;
   logic                  div_load_c;
   logic [KP_DIV_W-1:0]   div_val_c;
   logic [KP_WORD_W-1:0]  rx_word_c;

   // Divider reload: on start, and on every phase boundary while shifting.
   always_comb begin
      div_load_c = 1'b0;
      div_val_c  = HALF_LOAD;
      if (state == IDLE) begin
         div_load_c = TRG;
         if (MOD) begin
            div_val_c = LATCH_LOAD;
         end
      end else if (state == LATCH || state == LOW || state == HIGH) begin
         div_load_c = tick_c;
      end
   end

   fx_kport_clkdiv u_clkdiv (
      .clk      (CLK),
      .rst      (RES),
      .ce       (CE),
      .load     (div_load_c),
      .load_val (div_val_c),
      .tick_c   (tick_c)
   );

   // First received bit sits at 32-NBITS after NBITS right shifts.
   assign rx_word_c = shift >> RSHIFT;

   always_ff @(posedge CLK or posedge RES) begin
      if (RES) begin
         state    <= IDLE;
         shift    <= '0;
         bit_cnt  <= '0;
         RDATA    <= '0;
         BUSY     <= 1'b0;
         END      <= 1'b0;
         INT      <= 1'b0;
         KP_LATCH <= 1'b0;
         KP_CLK   <= 1'b1;
         KP_DOUT  <= 1'b0;
`ifdef FX_KPORT_PRESENCE_EN
         PRESENT  <= 1'b0;
`endif
      end else if (CE) begin
         INT <= 1'b0;
         if (RD_ACK) begin
            END <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (TRG) begin
                  shift   <= IOS ? WDATA : '0;
                  bit_cnt <= '0;
                  BUSY    <= 1'b1;
                  if (MOD) begin
                     KP_LATCH <= 1'b1;
                     state    <= LATCH;
                  end else begin
                     KP_CLK  <= 1'b0;
                     KP_DOUT <= IOS & WDATA[0];
                     state   <= LOW;
                  end
               end
            end
            LATCH: begin
               if (tick_c) begin
                  KP_LATCH <= 1'b0;
                  KP_CLK   <= 1'b0;
                  KP_DOUT  <= shift[0];
                  state    <= LOW;
               end
            end
            LOW: begin
               if (tick_c) begin
                  shift  <= {KP_DIN, shift[KP_WORD_W-1:1]};
                  KP_CLK <= 1'b1;
                  state  <= HIGH;
               end
            end
            HIGH: begin
               if (tick_c) begin
                  if (bit_cnt == LAST_BIT) begin
                     KP_DOUT <= 1'b0;
                     state   <= DONE;
                  end else begin
                     bit_cnt <= bit_cnt + KP_CNT_W'(1);
                     KP_CLK  <= 1'b0;
                     KP_DOUT <= shift[0];
                     state   <= LOW;
                  end
               end
            end
            DONE: begin
               RDATA <= rx_word_c;
               END   <= 1'b1;
               INT   <= 1'b1;
               BUSY  <= 1'b0;
`ifdef FX_KPORT_PRESENCE_EN
               PRESENT <= (rx_word_c[KP_WORD_W-1 -: 4] == PAD_ID);
`endif
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifndef FX_KPORT_PRESENCE_EN
   assign PRESENT = 1'b1;
`endif

endmodule

// File: tb/tb_fx_kport_ctl.sv
// Self-checking bench for fx_kport_ctl: directed plan plus randomized transfers vs. a transfer-level model.
module tb_fx_kport_ctl;

   logic        clk = 1'b0;
   logic        res = 1'b1;
   logic        mod = 1'b0;
   logic        ios = 1'b0;
   logic [31:0] wdata = '0;
   logic        rd_ack = 1'b0;

   logic        ce_a = 1'b1, trg_a = 1'b0, din_a = 1'b0;
   logic [31:0] rdata_a;
   logic        busy_a, end_a, int_a, present_a, latch_a, kclk_a, dout_a;

   logic        ce_b = 1'b0, trg_b = 1'b0, din_b = 1'b0;
   logic [31:0] rdata_b;
   logic        busy_b, end_b, int_b, present_b, latch_b, kclk_b, dout_b;

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   fx_kport_ctl #(.CLK_DIV(4), .NBITS(32)) u_a (
      .CLK(clk), .RES(res), .CE(ce_a), .TRG(trg_a), .MOD(mod), .IOS(ios),
      .WDATA(wdata), .RD_ACK(rd_ack), .RDATA(rdata_a), .BUSY(busy_a), .END(end_a),
      .INT(int_a), .PRESENT(present_a), .KP_LATCH(latch_a), .KP_CLK(kclk_a),
      .KP_DOUT(dout_a), .KP_DIN(din_a)
   );

   fx_kport_ctl #(.CLK_DIV(2), .NBITS(8)) u_b (
      .CLK(clk), .RES(res), .CE(ce_b), .TRG(trg_b), .MOD(mod), .IOS(ios),
      .WDATA(wdata), .RD_ACK(rd_ack), .RDATA(rdata_b), .BUSY(busy_b), .END(end_b),
      .INT(int_b), .PRESENT(present_b), .KP_LATCH(latch_b), .KP_CLK(kclk_b),
      .KP_DOUT(dout_b), .KP_DIN(din_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic exp_present(input logic [31:0] word);
`ifdef FX_KPORT_PRESENCE_EN
      return word[31:28] == 4'hF;
`else
      return 1'b1;
`endif
   endfunction

   function automatic logic reset_present();
`ifdef FX_KPORT_PRESENCE_EN
      return 1'b0;
`else
      return 1'b1;
`endif
   endfunction

   // One full transfer on instance A (CE always 1, CLK_DIV=4, NBITS=32) with a pad model.
   task automatic xfer_a(input logic m, input logic io, input logic [31:0] wd,
                         input logic [31:0] pw, input bit ack_done, input bit retrig);
      int lat, int_edge, int_w, falls, latch_n, dout_ones, busy_seen;
      logic [31:0] dout_w;
      logic prev_clk;
      lat = (m ? 2 * 4 : 0) + 2 * 4 * 32 + 1;
      int_edge = -1; int_w = 0; falls = 0; latch_n = 0; dout_ones = 0; busy_seen = 0;
      dout_w = '0; prev_clk = 1'b1;
      @(negedge clk);
      mod = m; ios = io; wdata = wd; trg_a = 1'b1;
      for (int k = 1; k <= lat + 20; k++) begin
         @(negedge clk);
         trg_a  = retrig && (k == 20);
         rd_ack = ack_done && (k == lat);
         if (k == 5) busy_seen = int'(busy_a);
         if (latch_a) latch_n++;
         if (prev_clk && !kclk_a) begin
            if (falls < 32) begin
               din_a = pw[falls];
               dout_w[falls] = dout_a;
            end
            falls++;
         end
         prev_clk = kclk_a;
         if (dout_a) dout_ones++;
         if (int_a) begin
            int_w++;
            if (int_edge < 0) int_edge = k - 1;
         end
      end
      trg_a = 1'b0; rd_ack = 1'b0;
      chk("busy_during", 32'(busy_seen), 32'(1));
      chk("int_latency", 32'(int_edge), 32'(lat));
      chk("int_width", 32'(int_w), 32'(1));
      chk("latch_cycles", 32'(latch_n), m ? 32'(8) : 32'(0));
      chk("clk_pulses", 32'(falls), 32'(32));
      chk("dout_word", dout_w, io ? wd : 32'h0);
      if (!io) chk("dout_zero", 32'(dout_ones), 32'(0));
      chk("rdata", rdata_a, pw);
      chk("end_set", 32'(end_a), 32'(1));
      chk("busy_clr", 32'(busy_a), 32'(0));
      chk("present", 32'(present_a), 32'(exp_present(pw)));
   endtask

   // One 8-bit transfer on instance B (CLK_DIV=2) with CE asserted one clock in three.
   task automatic xfer_b(input logic [7:0] pw);
      int cyc, ce_idx, since, bad, falls, int_idx;
      bit started;
      logic prev_clk;
      cyc = 0; ce_idx = 0; since = 0; bad = 0; falls = 0; int_idx = -1;
      started = 0; prev_clk = 1'b1;
      @(negedge clk);
      mod = 1'b0; ios = 1'b0; trg_b = 1'b1; ce_b = 1'b1; cyc = 1;
      for (int k = 0; k < 3 * 50; k++) begin
         @(negedge clk);
         if (ce_b) begin
            if (trg_b) begin
               trg_b = 1'b0; started = 1; ce_idx = 0; since = 0;
               if (!kclk_b) begin
                  din_b = pw[0]; falls = 1;
               end
               prev_clk = kclk_b;
            end else if (started) begin
               ce_idx++; since++;
            end
         end
         if (started && kclk_b != prev_clk) begin
            if (since != 2) bad++;
            since = 0;
            if (!kclk_b) begin
               if (falls < 8) din_b = pw[falls];
               falls++;
            end
            prev_clk = kclk_b;
         end
         if (started && int_b && int_idx < 0) int_idx = ce_idx;
         ce_b = (cyc % 3 == 0);
         cyc++;
      end
      ce_b = 1'b0;
      chk("b_int_latency", 32'(int_idx), 32'(2 * 2 * 8 + 1));
      chk("b_phase_len", 32'(bad), 32'(0));
      chk("b_clk_pulses", 32'(falls), 32'(8));
      chk("b_rdata", rdata_b, {24'h0, pw});
      chk("b_present", 32'(present_b), 32'(exp_present({24'h0, pw})));
   endtask

   task automatic chk_reset_a(input string tag);
      chk({tag, "_rdata"}, rdata_a, 32'h0);
      chk({tag, "_busy"}, 32'(busy_a), 32'(0));
      chk({tag, "_end"}, 32'(end_a), 32'(0));
      chk({tag, "_int"}, 32'(int_a), 32'(0));
      chk({tag, "_present"}, 32'(present_a), 32'(reset_present()));
      chk({tag, "_latch"}, 32'(latch_a), 32'(0));
      chk({tag, "_kclk"}, 32'(kclk_a), 32'(1));
      chk({tag, "_dout"}, 32'(dout_a), 32'(0));
   endtask

   initial begin
      int guard, seen_int;
      logic [31:0] pw;
      logic [7:0]  pb;

      // Reset state.
      repeat (3) @(negedge clk);
      chk_reset_a("rst");
      chk("rst_b_kclk", 32'(kclk_b), 32'(1));
      chk("rst_b_busy", 32'(busy_b), 32'(0));
      res = 1'b0;
      repeat (2) @(negedge clk);

      // Basic read with latch pulse.
      xfer_a(1'b1, 1'b0, 32'hDEAD_BEEF, 32'hF000_00A5, 1'b0, 1'b0);
      // Write-only, no latch.
      xfer_a(1'b0, 1'b1, 32'h1234_5678, 32'h0F0F_1234, 1'b0, 1'b0);

      // Retrigger while busy is ignored; RD_ACK coincident with DONE leaves END set.
      xfer_a(1'b1, 1'b1, 32'hA5A5_5A5A, 32'hF123_4567, 1'b1, 1'b1);
      @(negedge clk); rd_ack = 1'b1;
      @(negedge clk); rd_ack = 1'b0;
      chk("end_cleared", 32'(end_a), 32'(0));
      @(negedge clk); rd_ack = 1'b1;
      @(negedge clk); rd_ack = 1'b0;
      chk("end_stays_clear", 32'(end_a), 32'(0));
      chk("rdata_hold", rdata_a, 32'hF123_4567);

      // Async reset during HIGH of bit 10.
      @(negedge clk);
      mod = 1'b1; ios = 1'b1; wdata = 32'hFFFF_FFFF; trg_a = 1'b1;
      begin
         int falls;
         logic prev_clk;
         falls = 0; prev_clk = 1'b1; guard = 0;
         @(negedge clk); trg_a = 1'b0;
         while (!(falls == 11 && kclk_a) && guard < 400) begin
            if (prev_clk && !kclk_a) falls++;
            prev_clk = kclk_a;
            @(negedge clk);
            guard++;
         end
         chk("reach_bit10_high", 32'(guard < 400), 32'(1));
      end
      #2 res = 1'b1;
      #1 chk_reset_a("abort");
      @(negedge clk); res = 1'b0;
      seen_int = 0;
      repeat (300) begin
         @(negedge clk);
         if (int_a || end_a) seen_int++;
      end
      chk("abort_no_int_end", 32'(seen_int), 32'(0));
      xfer_a(1'b0, 1'b0, 32'h0, 32'hF00D_CAFE, 1'b0, 1'b0);

      // Reduced-width instance with sparse CE.
      xfer_b(8'h3C);

      // Randomized transfers against the model.
      for (int r = 0; r < 6; r++) begin
         pw = $urandom;
         if ($urandom_range(1, 0) == 1) pw[31:28] = 4'hF;
         xfer_a(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), $urandom, pw,
                bit'($urandom_range(1, 0)), bit'($urandom_range(1, 0)));
      end
      for (int r = 0; r < 3; r++) begin
         pb = 8'($urandom);
         xfer_b(pb);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
